clarvi_data_mem_responder: RTL and testbench
============================================

Name: clarvi_data_mem_responder

Overview:
- Memory-side responder for the Clarvi data port: receives word-addressed 64-bit load/store requests from the load/store stage and answers them.
- Stores byte-enabled writes into an internal RAM of 2^DATA_ADDR_WIDTH 64-bit words.
- Returns read data after a fixed, parameterised latency with a one-cycle valid strobe.
- After reset, zero-fills the whole RAM, holding waitrequest high until the fill completes.

Parameters:
DATA_ADDR_WIDTH, 14, word-address width; RAM depth = 2^DATA_ADDR_WIDTH 64-bit words
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal 1..4
HIGH_BITS_WIDTH, 61-DATA_ADDR_WIDTH, width of address_high_bits (derived, do not override)

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
address_high_bits  in  HIGH_BITS_WIDTH  upper byte-address bits beyond RAM range
main_address  in  DATA_ADDR_WIDTH  word address
main_byte_enable  in  8  byte lanes for write; ignored for read
main_read_enable  in  1  read request
main_write_enable  in  1  write request
main_write_data  in  64  lane-aligned store data
waitrequest  out  1  high = request not accepted this cycle
readdata  out  64  full 64-bit word, lanes not masked
readdatavalid  out  1  one-cycle strobe per accepted read
access_error  out  1  one-cycle strobe on rejected access (range-check build only; else tied 0)
init_done  out  1  high once the post-reset zero-fill has finished

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to INIT with fill counter 0.
  - waitrequest=1, readdatavalid=0, readdata=0, access_error=0, init_done=0.
  - The read pipeline is flushed.
- FSM: INIT -> READY.
  - INIT: write 64'h0 to word[fill counter] each cycle and increment the counter.
  - Leave INIT in the cycle the counter equals 2^DATA_ADDR_WIDTH-1, so the fill takes exactly 2^DATA_ADDR_WIDTH cycles.
  - READY: waitrequest=0 and init_done=1 from the first READY cycle.
  - No transition other than reset leaves READY.
  - Reset asserted mid-INIT restarts the fill from word 0.
- Acceptance: a request is accepted on a rising edge when waitrequest=0 and (read_enable or write_enable). While waitrequest=1, requests are ignored; the requester holds them.
- Write: lanes with byte_enable[i]=1 update bits [8i+7:8i] at the accepting edge. Byte_enable 0 is a legal no-op.
- Read:
  - The word is sampled after any same-edge write, so write-first ordering applies.
  - readdata is presented with readdatavalid=1 exactly READ_LATENCY edges after acceptance.
  - One read per cycle, fully pipelined, responses in order.
  - readdata holds its last value while readdatavalid=0.
- Read and write enables both high in the same request: perform the write, then return the post-write word.
- Back-to-back write then read of the same address on consecutive cycles returns the written data.
- Reset during outstanding reads discards them; no readdatavalid follows reset release.
- Without range checking, address_high_bits is ignored and the address wraps modulo the depth.

Optional Feature:
CLARVI_DMEM_RANGE_CHECK_EN
- Defined:
  - An accepted request with address_high_bits != 0 is rejected: the write is dropped and the RAM is unchanged.
  - access_error pulses for 1 cycle at acceptance+1.
  - A rejected read still returns readdatavalid on schedule, with readdata=64'h0, to keep the pipeline in order.
- Undefined: access_error tied 0 and no checking logic is generated.

Test Plan:
- Zero-fill: DATA_ADDR_WIDTH=4, release reset -> waitrequest stays high for exactly 16 cycles, then init_done=1; reads of all 16 words return 64'h0.
- Byte lanes: write 64'h1122334455667788 to address 5 with byte_enable=8'hFF, then 64'hAAAA_0000_0000_0000 with byte_enable=8'hC0 -> read of 5 returns 64'hAAAA334455667788.
- Latency: READ_LATENCY=3, reads of addresses 1, 2, 3 on consecutive cycles -> readdatavalid high in cycles +3, +4, +5 with the matching data in order.
- Write-first: write 64'hDEAD to address 7, read address 7 on the next cycle, and also a same-cycle read+write -> every read returns 64'hDEAD.
- Reset: assert reset_n low while two reads are in flight and midway through INIT -> no readdatavalid afterwards; the fill restarts and takes the full 16 cycles.
- Range check (macro defined): write with address_high_bits=1 to address 2 -> access_error pulses once and word 2 stays 0. Read with high bits=1 -> readdata=0 with valid on schedule. Without the macro, the same write lands in word 2.

Source files
------------

// File: rtl/clarvi_data_mem_responder_if.sv
// Clarvi data-port bus between the load/store stage and the data memory.
// Master drives requests; slave answers with waitrequest and read data.
interface clarvi_data_mem_responder_if #(
  parameter int DATA_ADDR_WIDTH = 14
);
  localparam int HIGH_BITS_WIDTH = 61 - DATA_ADDR_WIDTH;

  logic [HIGH_BITS_WIDTH-1:0] address_high_bits;
  logic [DATA_ADDR_WIDTH-1:0] main_address;
  logic [7:0]                 main_byte_enable;
  logic                       main_read_enable;
  logic                       main_write_enable;
  logic [63:0]                main_write_data;
  logic                       waitrequest;
  logic [63:0]                readdata;
  logic                       readdatavalid;
  logic                       access_error;
  logic                       init_done;

  modport master (
    output address_high_bits,
    output main_address,
    output main_byte_enable,
    output main_read_enable,
    output main_write_enable,
    output main_write_data,
    input  waitrequest,
    input  readdata,
    input  readdatavalid,
    input  access_error,
    input  init_done
  );

  modport slave (
    input  address_high_bits,
    input  main_address,
    input  main_byte_enable,
    input  main_read_enable,
    input  main_write_enable,
    input  main_write_data,
    output waitrequest,
    output readdata,
    output readdatavalid,
    output access_error,
    output init_done
  );
endinterface

// File: rtl/clarvi_data_mem_responder.sv
// Clarvi data memory responder: zero-filled RAM, byte-lane stores, pipelined reads.
// Define CLARVI_DMEM_RANGE_CHECK_EN to reject accesses with nonzero high address bits.
module clarvi_data_mem_responder #(
  parameter int DATA_ADDR_WIDTH = 14,
  parameter int READ_LATENCY    = 1
) (
  input logic clock,
  input logic reset_n,
  clarvi_data_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << DATA_ADDR_WIDTH;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_ADDR_WIDTH-1:0] fill_cnt;
  logic [63:0] mem [DEPTH];

  logic waitreq;
  logic done;
  logic acc;
  logic rd_acc;
  logic wr_acc;
  logic reject;
  logic err_q;

  logic [63:0] bmask;
  logic [63:0] cur_word;
  logic [63:0] merged;

  logic [READ_LATENCY-1:0] pipe_v;
  logic [63:0] pipe_d [READ_LATENCY];

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_INIT;
    else          state <= state_nxt;
  end

  // fill pointer walks every word once while in INIT
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              fill_cnt <= '0;
    else if (state == S_INIT)  fill_cnt <= fill_cnt + 1'b1;
  end

  // next state: READY after the last word is cleared, then stay
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:  if (fill_cnt == '1) state_nxt = S_READY;
      S_READY: state_nxt = S_READY;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    waitreq = 1'b1;
    done    = 1'b0;
    if (state == S_READY) begin
      waitreq = 1'b0;
      done    = 1'b1;
    end
  end

`ifdef CLARVI_DMEM_RANGE_CHECK_EN
  assign reject = |bus.address_high_bits;
`else
  logic unused_high_bits;
  assign unused_high_bits = ^bus.address_high_bits;
  assign reject = 1'b0;
`endif

  assign acc    = !waitreq
                & (bus.main_read_enable | bus.main_write_enable);
  assign rd_acc = acc & bus.main_read_enable;
  assign wr_acc = acc & bus.main_write_enable & !reject;

  // expand byte enables to a bit mask
  always_comb begin
    bmask = '0;
    for (int i = 0; i < 8; i++)
      bmask[8*i +: 8] = {8{bus.main_byte_enable[i]}};
  end

  assign cur_word = mem[bus.main_address];

  // post-write word: serves both the store and a same-edge read
  always_comb begin
    merged = cur_word;
    if (wr_acc)
      merged = (cur_word & ~bmask)
             | (bus.main_write_data & bmask);
    if (reject) merged = '0;
  end

  // RAM write port: zero-fill in INIT, masked stores once ready
  always_ff @(posedge clock) begin
    if (state == S_INIT)
      mem[fill_cnt] <= '0;
    else if (wr_acc)
      mem[bus.main_address] <= merged;
  end

  // read pipeline; stages keep data when no read passes through
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= rd_acc;
      if (rd_acc) pipe_d[0] <= merged;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

`ifdef CLARVI_DMEM_RANGE_CHECK_EN
  // one-cycle error strobe after a rejected acceptance
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= acc & reject;
  end
`else
  assign err_q = 1'b0;
`endif

  assign bus.waitrequest   = waitreq;
  assign bus.init_done     = done;
  assign bus.readdatavalid = pipe_v[READ_LATENCY-1];
  assign bus.readdata      = pipe_d[READ_LATENCY-1];
  assign bus.access_error  = err_q;
endmodule

// File: tb/tb_clarvi_data_mem_responder.sv
// Directed bench for clarvi_data_mem_responder.
// Scoreboard checks read data and the cycle each readdatavalid lands on.
module tb_clarvi_data_mem_responder;
  localparam int AW  = 4;
  localparam int LAT = 3;
  localparam int HBW = 61 - AW;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  clarvi_data_mem_responder_if #(.DATA_ADDR_WIDTH(AW)) bus();

  clarvi_data_mem_responder #(
    .DATA_ADDR_WIDTH(AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    int          at;
    logic [63:0] data;
  } exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vcount = 0;
  exp_t expq[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin : mon
    exp_t e;
    if (bus.readdatavalid === 1'b1) begin
      vcount++;
      if (expq.size() == 0) begin
        chk("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = expq.pop_front();
        chk("rd_cycle", 64'(cyc), 64'(e.at));
        chk("rd_data", bus.readdata, e.data);
      end
    end
  end

  task automatic clr();
    bus.main_read_enable  = 1'b0;
    bus.main_write_enable = 1'b0;
    bus.main_byte_enable  = '0;
    bus.main_address      = '0;
    bus.main_write_data   = '0;
    bus.address_high_bits = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic re,
                       input logic we,
                       input int a,
                       input logic [7:0] be,
                       input logic [63:0] wd,
                       input logic [HBW-1:0] hb,
                       input logic [63:0] exp);
    chk("wait_low", bus.waitrequest, 64'd0);
    bus.main_read_enable  = re;
    bus.main_write_enable = we;
    bus.main_address      = AW'(a);
    bus.main_byte_enable  = be;
    bus.main_write_data   = wd;
    bus.address_high_bits = hb;
    tick();
    if (re) expq.push_back('{at: cyc + LAT - 1, data: exp});
    clr();
  endtask

  task automatic drain();
    repeat (LAT + 2) tick();
  endtask

  task automatic count_init(output int n);
    n = 0;
    @(negedge clock);
    while (bus.waitrequest !== 1'b0 && n < 100) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int v0;
    clr();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_wait", bus.waitrequest, 64'd1);
    chk("rst_valid", bus.readdatavalid, 64'd0);
    chk("rst_rdata", bus.readdata, 64'd0);
    chk("rst_err", bus.access_error, 64'd0);
    chk("rst_done", bus.init_done, 64'd0);

    reset_n = 1'b1;
    count_init(n);
    chk("fill_cycles", 64'(n), 64'd16);
    chk("init_done", bus.init_done, 64'd1);
    tick();

    for (int i = 0; i < 16; i++)
      issue(1, 0, i, 8'h00, 64'h0, '0, 64'h0);
    drain();

    issue(0, 1, 5, 8'hFF, 64'h1122334455667788, '0, 64'h0);
    issue(0, 1, 5, 8'hC0, 64'hAAAA000000000000, '0, 64'h0);
    issue(1, 0, 5, 8'h00, 64'h0, '0, 64'hAAAA334455667788);
    issue(0, 1, 5, 8'h00, 64'hFFFFFFFFFFFFFFFF, '0, 64'h0);
    issue(1, 0, 5, 8'h00, 64'h0, '0, 64'hAAAA334455667788);
    drain();

    issue(0, 1, 1, 8'hFF, 64'h0101010101010101, '0, 64'h0);
    issue(0, 1, 2, 8'hFF, 64'h0202020202020202, '0, 64'h0);
    issue(0, 1, 3, 8'hFF, 64'h0303030303030303, '0, 64'h0);
    issue(1, 0, 1, 8'h00, 64'h0, '0, 64'h0101010101010101);
    issue(1, 0, 2, 8'h00, 64'h0, '0, 64'h0202020202020202);
    issue(1, 0, 3, 8'h00, 64'h0, '0, 64'h0303030303030303);
    drain();

    issue(0, 1, 7, 8'hFF, 64'hDEAD, '0, 64'h0);
    issue(1, 0, 7, 8'h00, 64'h0, '0, 64'hDEAD);
    issue(1, 1, 8, 8'hFF, 64'hDEAD, '0, 64'hDEAD);
    issue(0, 1, 9, 8'hFF, 64'h1111111111111111, '0, 64'h0);
    issue(1, 1, 9, 8'h01, 64'hFF, '0, 64'h11111111111111FF);
    drain();

    issue(0, 1, 2, 8'hFF, 64'hCAFE, HBW'(1), 64'h0);
    @(negedge clock);
`ifdef CLARVI_DMEM_RANGE_CHECK_EN
    chk("err_pulse", bus.access_error, 64'd1);
    @(negedge clock);
    chk("err_clear", bus.access_error, 64'd0);
    drain();
    issue(1, 0, 2, 8'h00, 64'h0, '0, 64'h0);
    issue(1, 0, 5, 8'h00, 64'h0, HBW'(1), 64'h0);
    @(negedge clock);
    chk("err_rd_pulse", bus.access_error, 64'd1);
`else
    chk("err_tied", bus.access_error, 64'd0);
    drain();
    issue(1, 0, 2, 8'h00, 64'h0, '0, 64'hCAFE);
    issue(1, 0, 5, 8'h00, 64'h0, HBW'(3), 64'hAAAA334455667788);
    issue(1, 0, 21, 8'h00, 64'h0, '0, 64'hAAAA334455667788);
`endif
    drain();

    v0 = vcount;
    issue(1, 0, 5, 8'h00, 64'h0, '0, 64'h0);
    issue(1, 0, 7, 8'h00, 64'h0, '0, 64'h0);
    #2;
    reset_n = 1'b0;
    expq.delete();
    #1;
    chk("flush_valid", bus.readdatavalid, 64'd0);
    chk("flush_rdata", bus.readdata, 64'd0);
    chk("flush_wait", bus.waitrequest, 64'd1);
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("mid_init_wait", bus.waitrequest, 64'd1);
    chk("mid_init_done", bus.init_done, 64'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    count_init(n);
    chk("refill_cycles", 64'(n), 64'd16);
    chk("valid_after_rst", 64'(vcount - v0), 64'd0);
    tick();

    issue(1, 0, 5, 8'h00, 64'h0, '0, 64'h0);
    issue(1, 0, 7, 8'h00, 64'h0, '0, 64'h0);
    issue(1, 0, 15, 8'h00, 64'h0, '0, 64'h0);
    drain();
    chk("queue_empty", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
